fpu_op_sequencer: RTL
=====================

# fpu_op_sequencer

Operand-load and result-capture sequencer wrapped around the FPU datapath. It takes an 8-bit byte stream from the host side and assembles operand A and operand B in the FPU's 32-bit format: sign[31], exponent[30:21] with bias 511, mantissa[20:0]. It holds the operands stable on the FPU inputs for a fixed compute window, then captures the FPU's data and status into an output register with a valid/ready handshake.

## Interface
- LATENCY, default 8: FPU compute window in clock cycles; legal range 1..255.
- FLUSH_DENORM, default 1: when 1, operands with exponent 0 and nonzero mantissa are flushed to signed zero before reaching the FPU.

Ports:
- clock_100Khz  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- byte_in  in  8  operand byte, MSB-first.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  sequencer accepts a byte this cycle.
- Op_A_out  out  32  operand A to the FPU.
- Op_B_out  out  32  operand B to the FPU.
- fpu_data_in  in  32  FPU result.
- fpu_status_in  in  4  FPU status: OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3.
- res_data  out  32  captured result.
- res_status  out  4  captured status.
- res_flushed  out  1  at least one operand of this operation was flushed.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- busy  out  1  high in WAIT and DONE.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE.
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - All outputs, the byte counter, the shift register and the wait counter are cleared to 0.
  - Reset takes effect in any state and discards a partial load or a pending result.
- IDLE:
  - Unconditionally moves to LOAD on the next edge.
  - byte_ready=0.
- LOAD:
  - byte_ready=1.
  - On each edge with byte_valid=1, byte_in shifts into a 64-bit shift register from the LSB end and the 3-bit counter increments.
  - Bytes 0-3 form A (byte 0 = A[31:24]); bytes 4-7 form B.
  - Gaps in byte_valid stall the load with no side effect.
  - On the edge that accepts byte 7:
    - Op_A_out and Op_B_out load the assembled operands, after any flush.
    - The counter wraps to 0 and the state goes to WAIT.
  - Op_A_out and Op_B_out keep their previous values during LOAD and never show partial operands.
- Flush, when FLUSH_DENORM=1:
  - An operand with exp==0 and mant!=0 becomes {sign, 31'b0}.
  - The flush flag is latched for that operation.
  - A true zero (exp==0, mant==0) is not flushed and does not set the flag.
- WAIT:
  - byte_ready=0; the wait counter counts LATENCY cycles.
  - On the edge ending the LATENCY-th WAIT cycle:
    - fpu_data_in → res_data, fpu_status_in → res_status, flush flag → res_flushed.
    - res_valid goes to 1 and the state goes to DONE.
- DONE:
  - res_valid=1 and result registers are held stable.
  - On an edge with res_ready=1: res_valid goes to 0 and the state goes to LOAD.
  - Op_A_out and Op_B_out keep their values.
- Bytes presented outside LOAD are not accepted (byte_ready=0); the source must hold them.

## Timing
- Let E be the edge that accepts byte 7.
  - Operands are visible on the FPU from E.
  - Capture happens at E+LATENCY; res_valid is high from E+LATENCY.
  - byte_ready returns to 1 on the edge after the handshake completes.
- Minimum period per operation: 8 + LATENCY + 1 cycles, with byte_valid held high and res_ready held high.
- busy=1 from E through the handshake edge.
- res_ready asserted before res_valid has no effect.
- The result handshake completes on the first edge where both res_valid and res_ready are 1.

## Test plan
- 2.0 + 1.0:
  - Stimulus: bytes 40 00 00 00 3F E0 00 00; FPU stub returns 0x40100000 with EXACT.
  - Required: Op_A_out=0x40000000 and Op_B_out=0x3FE00000 from E.
  - Required: res_valid rises at E+8 with res_data=0x40100000, res_status=2, res_flushed=0.
- Denormal flush:
  - Stimulus: A=0x00000001, B=0x80000005.
  - Required: Op_A_out=0x00000000, Op_B_out=0x80000000, res_flushed=1.
  - Repeat with A=0x00000000: no flush, res_flushed=0 (B=0x3FE00000).
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles after res_valid; change fpu_data_in meanwhile.
  - Required: res_data is unchanged, byte_ready=0 and busy=1 throughout; one-cycle res_ready completes the handshake and byte_ready=1 on the next edge.
- Gapped input:
  - Stimulus: byte_valid toggles every other cycle.
  - Required: same operands as a back-to-back load; Op outputs unchanged until byte 7.
- Reset mid-load:
  - Stimulus: reset=0 for one edge after 5 bytes.
  - Required: all outputs 0; the next 8 bytes form a fresh A/B, with no residue from the first 5.
- LATENCY=1:
  - Required: capture on the edge right after E, and correct values.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// Operand-load / result-capture sequencer for the FPU: assembles A and B from a
// byte stream, holds them for LATENCY cycles, then captures the FPU result.
module fpu_op_sequencer #(
   parameter int LATENCY      = 8,
   parameter bit FLUSH_DENORM = 1'b1
) (
   input  logic        clock_100Khz,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [31:0] Op_A_out,
   output logic [31:0] Op_B_out,
   input  logic [31:0] fpu_data_in,
   input  logic [3:0]  fpu_status_in,
   output logic [31:0] res_data,
   output logic [3:0]  res_status,
   output logic        res_flushed,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   function automatic logic is_denorm(input logic [31:0] w);
      return (w[30:21] == 10'd0) && (w[20:0] != 21'd0);
   endfunction

   function automatic logic [31:0] flush_op(input logic [31:0] w);
      if (FLUSH_DENORM && is_denorm(w)) return {w[31], 31'd0};
      else return w;
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [63:0] shift_q, shift_d;
   logic [7:0]  wait_q, wait_d;
   logic        flush_q, flush_d;
   logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic [31:0] res_data_q, res_data_d;
   logic [3:0]  res_status_q, res_status_d;
   logic        res_flushed_q, res_flushed_d;
   logic        res_valid_q, res_valid_d;
   logic        byte_ready_q, byte_ready_d;
   logic        busy_q, busy_d;
   logic [63:0] assembled_s;

   // Next-state and next-output logic; outputs are registered one edge ahead
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shift_d       = shift_q;
      wait_d        = wait_q;
      flush_d       = flush_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      res_data_d    = res_data_q;
      res_status_d  = res_status_q;
      res_flushed_d = res_flushed_q;
      res_valid_d   = res_valid_q;
      byte_ready_d  = byte_ready_q;
      busy_d        = busy_q;
      assembled_s   = {shift_q[55:0], byte_in};

      case (state_q)
         ST_IDLE: begin
            state_d      = ST_LOAD;
            byte_ready_d = 1'b1;
         end
         ST_LOAD: begin
            if (byte_valid) begin
               shift_d = assembled_s;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  op_a_d       = flush_op(assembled_s[63:32]);
                  op_b_d       = flush_op(assembled_s[31:0]);
                  flush_d      = FLUSH_DENORM && (is_denorm(assembled_s[63:32]) ||
                                                  is_denorm(assembled_s[31:0]));
                  wait_d       = 8'd0;
                  state_d      = ST_WAIT;
                  byte_ready_d = 1'b0;
                  busy_d       = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_WAIT: begin
            if (wait_q == LAT_M1) begin
               res_data_d    = fpu_data_in;
               res_status_d  = fpu_status_in;
               res_flushed_d = flush_q;
               res_valid_d   = 1'b1;
               state_d       = ST_DONE;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               res_valid_d  = 1'b0;
               byte_ready_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = ST_LOAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            byte_ready_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clock_100Khz) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 3'd0;
         shift_q       <= 64'd0;
         wait_q        <= 8'd0;
         flush_q       <= 1'b0;
         op_a_q        <= 32'd0;
         op_b_q        <= 32'd0;
         res_data_q    <= 32'd0;
         res_status_q  <= 4'd0;
         res_flushed_q <= 1'b0;
         res_valid_q   <= 1'b0;
         byte_ready_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         wait_q        <= wait_d;
         flush_q       <= flush_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         res_data_q    <= res_data_d;
         res_status_q  <= res_status_d;
         res_flushed_q <= res_flushed_d;
         res_valid_q   <= res_valid_d;
         byte_ready_q  <= byte_ready_d;
         busy_q        <= busy_d;
      end
   end

   assign byte_ready  = byte_ready_q;
   assign Op_A_out    = op_a_q;
   assign Op_B_out    = op_b_q;
   assign res_data    = res_data_q;
   assign res_status  = res_status_q;
   assign res_flushed = res_flushed_q;
   assign res_valid   = res_valid_q;
   assign busy        = busy_q;

endmodule
